// File: rtl/rescale_decode.sv
// Reconstructs NSAMP 3-bit codes per clock into NBITS-wide samples through a
// programmable 4-entry level table, and histograms the raw codes over a window.
module rescale_decode #(
    parameter int NSAMP   = 8,
    parameter int NBITS   = 12,
    parameter int CNTBITS = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NSAMP*3-1:0]       din,
    input  logic                     din_valid,
    input  logic                     level_wr,
    input  logic [1:0]               level_addr,
    input  logic [NBITS-2:0]         level_data,
    output logic [NSAMP*NBITS-1:0]   dout,
    output logic                     dout_valid,
    input  logic [15:0]              win_len,
    input  logic                     hist_start,
    output logic                     hist_busy,
    output logic                     hist_done,
    input  logic [2:0]               hist_sel,
    output logic [CNTBITS-1:0]       hist_count
);
    localparam int CW = $clog2(NSAMP + 1);
    localparam int SW = ((CNTBITS > CW) ? CNTBITS : CW) + 1;
    localparam logic [CNTBITS-1:0] BIN_MAX = '1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    logic [NBITS-2:0]         level_q [4];
    logic [NSAMP*3-1:0]       din_q;
    logic                     vld_q;
    logic [NSAMP*NBITS-1:0]   dout_q, dout_d;
    logic                     dout_valid_q;
    state_t                   state_q;
    logic [15:0]              win_q;
    logic [CNTBITS-1:0]       bin_q [8];
    logic [CNTBITS-1:0]       bin_d [8];
    logic [CW-1:0]            add_d [8];
    logic [CNTBITS-1:0]       count_q;
    logic                     busy_q, done_q;

    // Negative codes use a one's-complement image of the positive level.
    for (genvar g = 0; g < NSAMP; g++) begin : g_lane
        logic [2:0]       code;
        logic [1:0]       m;
        logic [NBITS-1:0] mag;
        assign code = din_q[3*g +: 3];
        assign m    = code[2] ? code[1:0] : ~code[1:0];
        assign mag  = {1'b0, level_q[m]};
        assign dout_d[NBITS*g +: NBITS] = code[2] ? mag : ~mag;
    end

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            add_d[k] = '0;
            for (int i = 0; i < NSAMP; i++) begin
                if (din[3*i +: 3] == 3'(k)) add_d[k] = add_d[k] + CW'(1);
            end
        end
    end

    // Widened sum so saturation can be detected before truncation.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            logic [SW-1:0] sum;
            sum = SW'(bin_q[k]) + SW'(add_d[k]);
            bin_d[k] = (sum > SW'(BIN_MAX)) ? BIN_MAX : sum[CNTBITS-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q[0]   <= (NBITS-1)'('h040);
            level_q[1]   <= (NBITS-1)'('h0C0);
            level_q[2]   <= (NBITS-1)'('h140);
            level_q[3]   <= (NBITS-1)'('h1C0);
            din_q        <= '0;
            vld_q        <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            state_q      <= IDLE;
            win_q        <= '0;
            for (int k = 0; k < 8; k++) bin_q[k] <= '0;
            count_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            if (level_wr) level_q[level_addr] <= level_data;
            din_q        <= din;
            vld_q        <= din_valid;
            dout_q       <= dout_d;
            dout_valid_q <= vld_q;
            count_q      <= bin_q[hist_sel];
            case (state_q)
                IDLE, DONE: begin
                    if (hist_start) begin
                        state_q <= RUN;
                        for (int k = 0; k < 8; k++) bin_q[k] <= '0;
                        win_q   <= (win_len == 16'd0) ? 16'd1 : win_len;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                RUN: begin
                    if (din_valid) begin
                        for (int k = 0; k < 8; k++) bin_q[k] <= bin_d[k];
                    end
                    win_q <= win_q - 16'd1;
                    if (win_q == 16'd1) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign hist_busy  = busy_q;
    assign hist_done  = done_q;
    assign hist_count = count_q;

endmodule

// File: doc/rescale_decode.md
RESCALE_DECODE -- requirements
Module: rescale_decode

Interface
REQ-001 SHALL have parameter NSAMP, default 8, samples per clock.
REQ-002 SHALL have parameter NBITS, default 12, reconstructed sample width, two's-complement-style.
REQ-003 SHALL have parameter CNTBITS, default 24, histogram bin width.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-006 SHALL have port din, input, NSAMP*3, 3-bit codes; sample i is at [3i+:3].
REQ-007 SHALL have port din_valid, input, 1, din qualifier.
REQ-008 SHALL have port level_wr, input, 1, level table write strobe.
REQ-009 SHALL have port level_addr, input, 2, level table index.
REQ-010 SHALL have port level_data, input, NBITS-1, level magnitude.
REQ-011 SHALL have port dout, output, NSAMP*NBITS, reconstructed samples; sample i is at [NBITS*i+:NBITS].
REQ-012 SHALL have port dout_valid, output, 1, dout qualifier.
REQ-013 SHALL have port win_len, input, 16, histogram window length in clocks.
REQ-014 SHALL have port hist_start, input, 1, start-window pulse.
REQ-015 SHALL have port hist_busy, output, 1, high while the window is running.
REQ-016 SHALL have port hist_done, output, 1, high while results are held.
REQ-017 SHALL have port hist_sel, input, 3, bin select.
REQ-018 SHALL have port hist_count, output, CNTBITS, value of the selected bin.

Function
REQ-019 SHALL decode each code c as follows:
- sign is negative when c[2]=0.
- magnitude index m = c[1:0] when c[2]=1, else ~c[1:0].
- Mapping: 4→0, 5→1, 6→2, 7→3; 3→0, 2→1, 1→2, 0→3.
REQ-020 SHALL compute the output as:
- Positive: dout_i = {1'b0, level[m]}.
- Negative: dout_i = ~{1'b0, level[m]} (bitwise inversion, no +1).
REQ-021 SHALL use a 2-stage pipeline:
- Stage 1 registers din and din_valid.
- Stage 2 registers the table lookup.
- dout_valid equals din_valid delayed 2 clocks.
- dout updates every clock regardless of valid.
REQ-022 SHALL write level[level_addr] <= level_data at any edge with level_wr=1.
REQ-023 SHALL produce stage-2 outputs registered at edge N+1 onward using a value written at edge N; no other output glitch is permitted.
REQ-024 SHALL implement histogram FSM state IDLE: on hist_start, go to RUN, clear all 8 bins, and load the window counter with max(win_len,1).
REQ-025 SHALL implement histogram FSM state RUN:
- Samples din at each of exactly win_len (min 1) edges following the start edge.
- At each edge with din_valid=1, adds to each bin[k] the number of samples with code k (0..NSAMP).
- Transitions to DONE on the final counted edge; that edge's data is included.
REQ-026 SHALL implement histogram FSM state DONE:
- Holds the bins.
- hist_start re-enters RUN with bins cleared.
REQ-027 SHALL ignore hist_start while in RUN.
REQ-028 SHALL drive hist_busy=1 only in RUN and hist_done=1 only in DONE.
REQ-029 SHALL saturate each bin at 2^CNTBITS-1, never wrapping.
REQ-030 SHALL register hist_count <= bin[hist_sel] each clock (1-clock latency), in every state.
REQ-031 SHALL apply a level write coincident with RUN to the decode path only; histograms count codes, not levels.

Reset
REQ-032 SHALL, while rst=1 at an edge, force:
- dout=0, dout_valid=0, stage-1 registers=0.
- FSM=IDLE, all bins=0, hist_count=0.
- level table = {0x040, 0x0C0, 0x140, 0x1C0} for indices 0..3.
REQ-033 SHALL give rst priority over level_wr and hist_start; rst in RUN aborts the window without setting hist_done.

Verification
REQ-034 SHALL verify defaults: release rst, din all codes 7, din_valid=1 → 2 clocks later every dout_i=12'h1C0 and dout_valid=1.
REQ-035 SHALL verify negative decode: codes 0 and 3 → 12'hE3F and 12'hFBF; codes 4 and 5 → 12'h040 and 12'h0C0.
REQ-036 SHALL verify level write: write level[1]=0x200; codes 5 and 2 → 12'h200 and 12'hDFF, from the output registered at the edge after the write.
REQ-037 SHALL verify histogram: win_len=4, all codes 4, valid continuous, hist_start pulse:
- hist_busy for 4 clocks, then hist_done.
- bin4=32, other bins=0.
- With din_valid low on one of the 4 clocks, bin4=24.
REQ-038 SHALL verify saturation and edge cases:
- CNTBITS=6, win_len=10, all codes 0 → bin0=63.
- win_len=0 counts 1 clock.
- hist_start during RUN has no effect.
REQ-039 SHALL verify reset in RUN: assert rst mid-window → FSM IDLE, all bins 0, hist_done=0, level table back to defaults.
